// File: rtl/tdc_ts_fifo.sv
// Timestamp capture stage: free-running coarse counter, {coarse,fine}
// words pushed into a FWFT FIFO with occupancy, overflow and drop count.
// Ports: wb_clk_i/wb_rst_i clock and async reset; rst_time_n_i async
//   coarse clear; evt_valid_i/evt_fine_i event in; rd_i pop; dat_o head;
//   empty_o/full_o/count_o occupancy; ovf_o/drop_cnt_o/ovf_clr_i overflow.
module tdc_ts_fifo #(
  parameter int COARSE_W = 24,
  parameter int FINE_W   = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       rst_time_n_i,
  input  logic                       evt_valid_i,
  input  logic [FINE_W-1:0]          evt_fine_i,
  input  logic                       rd_i,
  output logic [COARSE_W+FINE_W-1:0] dat_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [AW:0]                count_o,
  output logic                       ovf_o,
  output logic [7:0]                 drop_cnt_o,
  input  logic                       ovf_clr_i
);

  localparam int TW = COARSE_W + FINE_W;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic                sync1_q, sync2_q;
  logic [COARSE_W-1:0] coarse_q;
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         count_q, count_d;
  logic                ovf_q;
  logic [7:0]          drop_q, drop_d;
  logic [TW-1:0]       mem_q [DEPTH];

  logic rd_ok, wr_ok, drop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign rd_ok = rd_i && !empty_o;
  assign wr_ok = evt_valid_i && (!full_o || rd_ok);
  assign drop  = evt_valid_i && !wr_ok;

  assign count_d = count_q + {{AW{1'b0}}, wr_ok}
                           - {{AW{1'b0}}, rd_ok};

  // A drop coinciding with a clear restarts the count at one.
  always_comb begin
    drop_d = drop_q;
    if (drop) begin
      if (ovf_clr_i)
        drop_d = 8'd1;
      else if (drop_q != 8'hFF)
        drop_d = drop_q + 8'd1;
    end else if (ovf_clr_i) begin
      drop_d = 8'd0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      coarse_q <= '0;
    end else begin
      sync1_q  <= rst_time_n_i;
      sync2_q  <= sync1_q;
      coarse_q <= sync2_q ? coarse_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop)
        ovf_q <= 1'b1;
      else if (ovf_clr_i)
        ovf_q <= 1'b0;
      drop_q <= drop_d;
    end
  end

  // Storage needs no reset: it is hidden whenever the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= {coarse_q, evt_fine_i};
  end

  assign dat_o      = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign ovf_o      = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule
